iob_plic_gateway: RTL

Per-source interrupt gateway for the IOb PLIC. It converts raw `src` lines into one pending request per source and holds each request until a target claims it. It blocks re-assertion until the target writes completion. In edge mode it queues up to MAX_PENDING_COUNT extra rising edges. It sits between the external interrupt inputs and the PLIC priority/claim core.

---
 rtl/iob_plic_pkg.sv | 16 +
 rtl/iob_plic_gateway_cell.sv | 107 ++++++++++
 rtl/iob_plic_gateway.sv | 34 +++
 3 files changed

// File: rtl/iob_plic_pkg.sv
// Shared types and helpers for the PLIC interrupt gateway.
// State encoding of the per-source gateway FSM and counter sizing.
package iob_plic_pkg;

  typedef enum logic [1:0] {
    GW_IDLE    = 2'd0,
    GW_PENDING = 2'd1,
    GW_CLAIMED = 2'd2
  } gw_state_e;

  // Counter must hold 0..max_count inclusive.
  function automatic int gw_cnt_width(input int max_count);
    return $clog2(max_count + 1);
  endfunction

endpackage

// File: rtl/iob_plic_gateway_cell.sv
// One interrupt source: optional synchronizer, edge detect, FSM, queued-edge counter.
// Optional macro IOB_PLIC_GATEWAY_SYNC_EN adds a 2-flop synchronizer on src.
//
// state      | meaning
// GW_IDLE    | no request outstanding, watching src
// GW_PENDING | request presented to the core (ip=1)
// GW_CLAIMED | claimed by a target, waiting for completion
module iob_plic_gateway_cell
  import iob_plic_pkg::*;
#(
  parameter int MAX_PENDING_COUNT = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic src,
  input  logic edge_mode,
  input  logic claim,
  input  logic complete,
  output logic ip,
  output logic cnt_full
);

  localparam int CW = gw_cnt_width(MAX_PENDING_COUNT);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_PENDING_COUNT);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  gw_state_e     state_q, state_nxt;
  logic [CW-1:0] cnt_q, cnt_nxt;
  logic          src_s, src_q;
  logic          edge_ev, cnt_sat, cnt_zero;
  logic          ip_nxt, full_nxt;

`ifdef IOB_PLIC_GATEWAY_SYNC_EN
  logic [1:0] sync_ff;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) sync_ff <= 2'b00;
    else      sync_ff <= {sync_ff[0], src};
  end
  assign src_s = sync_ff[1];
`else
  assign src_s = src;
`endif

  assign edge_ev  = edge_mode & src_s & ~src_q;
  assign cnt_sat  = (cnt_q == CNT_MAX);
  assign cnt_zero = (cnt_q == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= GW_IDLE;
      cnt_q    <= '0;
      src_q    <= 1'b0;
      ip       <= 1'b0;
      cnt_full <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      cnt_q    <= cnt_nxt;
      src_q    <= src_s;
      ip       <= ip_nxt;
      cnt_full <= full_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    case (state_q)
      GW_IDLE: begin
        if (edge_mode ? edge_ev : src_s) state_nxt = GW_PENDING;
      end
      GW_PENDING: begin
        if (claim) state_nxt = GW_CLAIMED;
      end
      GW_CLAIMED: begin
        if (complete) begin
          // A queued edge or one arriving with the completion re-arms immediately.
          if (edge_mode && (!cnt_zero || edge_ev)) state_nxt = GW_PENDING;
          else                                     state_nxt = GW_IDLE;
        end
      end
      default: state_nxt = GW_IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt_q;
    if (!edge_mode) begin
      cnt_nxt = '0;
    end else begin
      case (state_q)
        GW_PENDING: begin
          if (edge_ev && !cnt_sat) cnt_nxt = cnt_q + CNT_ONE;
        end
        GW_CLAIMED: begin
          if (complete) begin
            if (!cnt_zero && !edge_ev) cnt_nxt = cnt_q - CNT_ONE;
          end else if (edge_ev && !cnt_sat) begin
            cnt_nxt = cnt_q + CNT_ONE;
          end
        end
        default: cnt_nxt = cnt_q;
      endcase
    end
    ip_nxt   = (state_nxt == GW_PENDING);
    full_nxt = (cnt_nxt == CNT_MAX);
  end

endmodule

// File: rtl/iob_plic_gateway.sv
// PLIC gateway: one independent gateway cell per interrupt source.
// Optional macro IOB_PLIC_GATEWAY_SYNC_EN synchronizes src inside every cell.
module iob_plic_gateway
  import iob_plic_pkg::*;
#(
  parameter int SOURCES           = 8,
  parameter int MAX_PENDING_COUNT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [SOURCES-1:0] src,
  input  logic [SOURCES-1:0] edge_mode,
  input  logic [SOURCES-1:0] claim,
  input  logic [SOURCES-1:0] complete,
  output logic [SOURCES-1:0] ip,
  output logic [SOURCES-1:0] cnt_full
);

  for (genvar g = 0; g < SOURCES; g++) begin : g_cell
    iob_plic_gateway_cell #(
      .MAX_PENDING_COUNT(MAX_PENDING_COUNT)
    ) u_cell (
      .clk      (clk),
      .rst      (rst),
      .src      (src[g]),
      .edge_mode(edge_mode[g]),
      .claim    (claim[g]),
      .complete (complete[g]),
      .ip       (ip[g]),
      .cnt_full (cnt_full[g])
    );
  end

endmodule
